clk_tick_monitor: RTL

- Receiving end of the divided-clock path in the egg-timer design.
- Takes a slow, toggled divided clock (nominal 500 Hz) back into the fast clk_in domain and synchronises it.
- Emits one-cycle tick strobes on each slow rising edge for the countdown/display logic.
- Measures each slow period in clk_in cycles and reports lock/loss status, so a stalled or mis-set divider is caught.

---
 rtl/clk_tick_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clk_tick_monitor.sv
// Receives the divided egg-timer clock into the clk_in domain, emits a tick per slow
// rising edge, measures each slow period and tracks lock / loss of the divider.
module clk_tick_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int EXP_PERIOD  = 10002,
    parameter int TOL         = 16,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                enable,
    input  logic                slow_clk,
    output logic                tick,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                lost,
    output logic [7:0]          err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [PERIOD_W-1:0] LO_LIM  = PERIOD_W'(EXP_PERIOD - TOL);
    localparam logic [PERIOD_W-1:0] HI_LIM  = PERIOD_W'(EXP_PERIOD + TOL);
    localparam logic [PERIOD_W-1:0] TO_LIM  = PERIOD_W'(EXP_PERIOD + TOL + 1);
    localparam logic [GW-1:0]       GOOD_LAST = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]          good_q, good_d;
    state_t                 state_q, state_d;
    logic                   tick_q, tick_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic                   pv_q, pv_d;
    logic                   locked_q, locked_d;
    logic                   lost_q, lost_d;
    logic [7:0]             err_q, err_d;

    logic s_s;
    logic rise_s;
    logic in_range_s;

    assign s_s        = sync_q[SYNC_STAGES-1];
    assign rise_s     = s_s & ~s_d_q;
    assign in_range_s = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);

    // Next-state: period measurement, lock FSM and error counting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        period_d = period_q;
        err_d    = err_q;
        tick_d   = 1'b0;
        pv_d     = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else if (rise_s) begin
            tick_d = 1'b1;
            cnt_d  = PERIOD_W'(1);
            if (state_q != ST_IDLE) begin
                pv_d     = 1'b1;
                period_d = cnt_q;
            end else begin
                pv_d     = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (in_range_s) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GOOD_LAST) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!in_range_s) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOST: begin
                    // The recovery rise measures a broken interval, so it never counts as good.
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                end
            endcase
        end else begin
            cnt_d = (cnt_q == {PERIOD_W{1'b1}}) ? cnt_q : cnt_q + PERIOD_W'(1);
            if (((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED)) && (cnt_q == TO_LIM)) begin
                state_d = ST_LOST;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Status flags are taken from the next state so they change on the same edge.
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
    end

    // State registers; the synchroniser and edge detector run regardless of enable.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            s_d_q    <= 1'b0;
            cnt_q    <= '0;
            good_q   <= '0;
            state_q  <= ST_IDLE;
            tick_q   <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            s_d_q    <= s_s;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            err_q    <= err_d;
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign err_count    = err_q;

endmodule
